ship_projectile_pool: RTL and testbench
=======================================

Name: ship_projectile_pool

Overview:
- Downstream stage of the ship fire-slot finder. It consumes the one-hot launch pulse ProjActvt and owns the NP ship projectile slots.
- Per slot it holds position and active state, and moves active projectiles upward once per frame.
- A slot is retired when its projectile leaves the top of the screen or the collision logic reports a hit.
- It reports ProjEn back to the finder so the finder can pick free slots, and feeds per-slot coordinates to the sprite renderer.

Parameters:
- NP, 10, number of projectile slots; must equal galaga_lib NP.
- COORD_W, 10, width of screen coordinates in bits.
- PROJ_SPEED, 6, pixels moved upward per frame.
- X_OFFSET, 15, horizontal offset from ShipX to the projectile spawn column.
- PROJ_H, 8, projectile height; spawn Y is ShipY - PROJ_H.

Ports:
- frame_clk  in  1  frame-rate clock, one edge per frame
- Reset  in  1  synchronous, active-high reset
- ProjActvt  in  NP  launch request, at most one bit per slot; bit i launches slot i
- ShipX  in  COORD_W  ship left-edge X, sampled at launch
- ShipY  in  COORD_W  ship top-edge Y, sampled at launch
- ProjHit  in  NP  collision report; bit i retires slot i
- Freeze  in  1  game pause; holds all slot positions
- ProjEn  out  NP  slot active flags, registered
- ProjX  out  NP*COORD_W  packed slot X coordinates; slot i occupies bits [i*COORD_W +: COORD_W]
- ProjY  out  NP*COORD_W  packed slot Y coordinates, same packing as ProjX

Behaviour:
- Clocking and reset:
  - One clock, frame_clk. All state updates on its rising edge. Reset is synchronous and active-high, named Reset.
  - Reset forces every slot to IDLE. ProjEn, ProjX and ProjY all go to 0.
  - A Reset mid-flight discards every in-flight projectile on that edge. Reset has priority over all other inputs.
- Slot state machine (galaga_lib enum proj_state_t): IDLE, FLY.
  - IDLE -> FLY when ProjActvt[i]=1 and Freeze=0.
    - Load X = ShipX + X_OFFSET, truncated to COORD_W bits.
    - Load Y = ShipY - PROJ_H. If ShipY < PROJ_H, load Y = 0 instead.
  - FLY -> IDLE when ProjHit[i]=1, regardless of Freeze. Position holds its last value.
  - FLY -> IDLE when Freeze=0 and Y < PROJ_SPEED, i.e. the projectile has reached the top. No wrap-around ever occurs.
  - FLY, Freeze=0, otherwise: Y <= Y - PROJ_SPEED. X is unchanged.
  - FLY, Freeze=1, no hit: hold X and Y.
  - In IDLE, X and Y hold their last values. The renderer must gate on ProjEn.
- Simultaneous events:
  - ProjActvt[i] while slot i is in FLY is ignored. No relaunch, no position change.
  - ProjHit[i] while slot i is in IDLE is ignored.
  - ProjHit[i] and ProjActvt[i] together in IDLE: the launch proceeds.
  - ProjHit[i] together with a top-exit condition: the slot goes to IDLE once; no double event.
  - ProjActvt with Freeze=1: the launch is dropped, not deferred.
  - Multiple ProjActvt bits in one cycle: each slot acts independently.
- Latency:
  - ProjActvt high at edge k -> ProjEn[i]=1 and spawn coordinates visible after edge k.
  - First movement happens at edge k+1.
  - ProjEn is registered, so the finder sees the slot as busy one frame after its own pulse.
- ProjEn[i] = (state_i == FLY).

Optional Feature:
- Macro: PROJ_SHOT_STATS_EN.
- With the macro defined:
  - Extra outputs ShotsFired[15:0] and ShotsHit[15:0].
  - ShotsFired increments by the number of accepted launches in the cycle, using a popcount.
  - ShotsHit increments by the number of FLY slots retired by ProjHit.
  - Both counters saturate at 16'hFFFF and clear on Reset.
- Without the macro: the ports and counters are absent. All other behaviour is identical.

Decomposition:
- galaga_lib holds NP, COORD_W, PROJ_SPEED, X_OFFSET, PROJ_H defaults and proj_state_t.
- Sub-module proj_slot: one slot's FSM and position registers. The pool instantiates NP copies with a generate loop and adds the packing logic and the optional stats logic.

Test Plan:
- Reset, then ProjActvt=10'h001 with ShipX=300, ShipY=440 -> next frame ProjEn=10'h001, X0=315, Y0=432. Frame after that Y0=426.
- Slot 0 launched at Y0=10 -> next frame Y0=4. Frame after that ProjEn[0]=0 (4 < 6), with no wrap to a large value.
- Slot 3 in FLY; ProjHit=10'h008 and ProjActvt=10'h008 in the same frame -> ProjEn[3]=0. Next frame ProjActvt=10'h008 relaunches slot 3.
- Freeze=1 for 5 frames with slots 0 and 1 flying; ProjActvt=10'h004 during Freeze -> positions constant, slot 2 stays IDLE. ProjHit[1] retires slot 1.
- Slots 0..9 all flying; assert Reset for one edge -> ProjEn=0 and all coordinates 0 on that edge.
- With PROJ_SHOT_STATS_EN: 3 launches and then 2 hits -> ShotsFired=3, ShotsHit=2. Preload ShotsFired to 16'hFFFF, launch again -> stays 16'hFFFF.

Source files
------------

// File: rtl/galaga_lib.sv
// Shared constants and types for the Galaga ship projectile path.
package galaga_lib;
    localparam int NP         = 10;
    localparam int COORD_W    = 10;
    localparam int PROJ_SPEED = 6;
    localparam int X_OFFSET   = 15;
    localparam int PROJ_H     = 8;

    typedef enum logic {IDLE = 1'b0, FLY = 1'b1} proj_state_t;

    function automatic int popcount(input logic [NP-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < NP; i++) n += int'(v[i]);
        return n;
    endfunction
endpackage

// File: rtl/ship_projectile_pool_slot.sv
// One ship projectile slot: IDLE/FLY state machine plus position registers.
import galaga_lib::*;

module proj_slot #(
    parameter int COORD_W    = galaga_lib::COORD_W,
    parameter int PROJ_SPEED = galaga_lib::PROJ_SPEED,
    parameter int X_OFFSET   = galaga_lib::X_OFFSET,
    parameter int PROJ_H     = galaga_lib::PROJ_H
) (
    input  logic               frame_clk,
    input  logic               Reset,
    input  logic               activate,
    input  logic               hit,
    input  logic               freeze,
    input  logic [COORD_W-1:0] ship_x,
    input  logic [COORD_W-1:0] ship_y,
    output logic               en,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y
);
    localparam logic [COORD_W-1:0] SPEED = COORD_W'(PROJ_SPEED);
    localparam logic [COORD_W-1:0] XOFF  = COORD_W'(X_OFFSET);
    localparam logic [COORD_W-1:0] HGT   = COORD_W'(PROJ_H);

    proj_state_t state, next_state;
    logic        launch, move;

    always_ff @(posedge frame_clk) begin
        if (Reset) state <= IDLE;
        else       state <= next_state;
    end

    // Hit takes precedence over top exit so a slot retires exactly once.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (activate && !freeze) next_state = FLY;
            FLY: begin
                if (hit)                        next_state = IDLE;
                else if (!freeze && y < SPEED)  next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        en     = (state == FLY);
        launch = (state == IDLE) && activate && !freeze;
        move   = (state == FLY) && !hit && !freeze && (y >= SPEED);
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            x <= '0;
            y <= '0;
        end else if (launch) begin
            x <= ship_x + XOFF;
            y <= (ship_y < HGT) ? '0 : ship_y - HGT;
        end else if (move) begin
            y <= y - SPEED;
        end
    end
endmodule

// File: rtl/ship_projectile_pool.sv
// Pool of NP ship projectile slots with packed coordinate outputs.
// Optional shot statistics counters are enabled with PROJ_SHOT_STATS_EN.
import galaga_lib::*;

module ship_projectile_pool #(
    parameter int NP         = galaga_lib::NP,
    parameter int COORD_W    = galaga_lib::COORD_W,
    parameter int PROJ_SPEED = galaga_lib::PROJ_SPEED,
    parameter int X_OFFSET   = galaga_lib::X_OFFSET,
    parameter int PROJ_H     = galaga_lib::PROJ_H
) (
    input  logic                  frame_clk,
    input  logic                  Reset,
    input  logic [NP-1:0]         ProjActvt,
    input  logic [COORD_W-1:0]    ShipX,
    input  logic [COORD_W-1:0]    ShipY,
    input  logic [NP-1:0]         ProjHit,
    input  logic                  Freeze,
    output logic [NP-1:0]         ProjEn,
    output logic [NP*COORD_W-1:0] ProjX,
    output logic [NP*COORD_W-1:0] ProjY
`ifdef PROJ_SHOT_STATS_EN
    ,
    output logic [15:0]           ShotsFired,
    output logic [15:0]           ShotsHit
`endif
);
    logic [NP-1:0][COORD_W-1:0] slot_x, slot_y;

    for (genvar i = 0; i < NP; i++) begin : g_slot
        proj_slot #(
            .COORD_W(COORD_W), .PROJ_SPEED(PROJ_SPEED),
            .X_OFFSET(X_OFFSET), .PROJ_H(PROJ_H)
        ) u_slot (
            .frame_clk (frame_clk),
            .Reset     (Reset),
            .activate  (ProjActvt[i]),
            .hit       (ProjHit[i]),
            .freeze    (Freeze),
            .ship_x    (ShipX),
            .ship_y    (ShipY),
            .en        (ProjEn[i]),
            .x         (slot_x[i]),
            .y         (slot_y[i])
        );
    end

    assign ProjX = slot_x;
    assign ProjY = slot_y;

`ifdef PROJ_SHOT_STATS_EN
    // ProjEn mirrors the FLY state, so acceptance can be derived here.
    logic [NP-1:0] launch_acc, hit_acc;
    logic [16:0]   fired_sum, hit_sum;

    always_comb begin
        launch_acc = ProjActvt & ~ProjEn & {NP{~Freeze}};
        hit_acc    = ProjHit & ProjEn;
        fired_sum  = {1'b0, ShotsFired} + 17'(popcount(launch_acc));
        hit_sum    = {1'b0, ShotsHit}   + 17'(popcount(hit_acc));
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            ShotsFired <= '0;
            ShotsHit   <= '0;
        end else begin
            ShotsFired <= fired_sum[16] ? 16'hFFFF : fired_sum[15:0];
            ShotsHit   <= hit_sum[16]   ? 16'hFFFF : hit_sum[15:0];
        end
    end
`endif
endmodule

// File: tb/tb_ship_projectile_pool.sv
// Directed self-checking bench for ship_projectile_pool.
module tb_ship_projectile_pool;
    localparam int NP = 10;
    localparam int CW = 10;

    logic             frame_clk = 1'b0;
    logic             Reset;
    logic [NP-1:0]    ProjActvt, ProjHit;
    logic [CW-1:0]    ShipX, ShipY;
    logic             Freeze;
    logic [NP-1:0]    ProjEn;
    logic [NP*CW-1:0] ProjX, ProjY;
`ifdef PROJ_SHOT_STATS_EN
    logic [15:0]      ShotsFired, ShotsHit;
`endif

    int checks = 0;
    int errors = 0;

    ship_projectile_pool dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .ProjActvt (ProjActvt),
        .ShipX     (ShipX),
        .ShipY     (ShipY),
        .ProjHit   (ProjHit),
        .Freeze    (Freeze),
        .ProjEn    (ProjEn),
        .ProjX     (ProjX),
`ifdef PROJ_SHOT_STATS_EN
        .ProjY     (ProjY),
        .ShotsFired(ShotsFired),
        .ShotsHit  (ShotsHit)
`else
        .ProjY     (ProjY)
`endif
    );

    always #5 frame_clk = ~frame_clk;

    function automatic logic [CW-1:0] px(input int i);
        return ProjX[i*CW +: CW];
    endfunction

    function automatic logic [CW-1:0] py(input int i);
        return ProjY[i*CW +: CW];
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic idle_inputs();
        ProjActvt = '0;
        ProjHit   = '0;
        Freeze    = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; idle_inputs(); ShipX = 10'd300; ShipY = 10'd440;
        tick();
        check("reset_en", ProjEn, 0);
        check("reset_x",  ProjX, 0);
        check("reset_y",  ProjY, 0);

        // Basic launch and first movement
        Reset = 1'b0; ProjActvt = 10'h001;
        tick();
        ProjActvt = '0;
        check("launch_en", ProjEn, 10'h001);
        check("launch_x0", px(0), 315);
        check("launch_y0", py(0), 432);
        tick();
        check("move_y0", py(0), 426);
        check("move_x0", px(0), 315);

        // Top exit without wrap
        Reset = 1'b1; tick(); Reset = 1'b0;
        ShipY = 10'd18; ProjActvt = 10'h001;
        tick(); ProjActvt = '0;
        check("top_y10", py(0), 10);
        tick();
        check("top_y4", py(0), 4);
        check("top_en_still", ProjEn, 10'h001);
        tick();
        check("top_exit_en", ProjEn, 0);
        check("top_nowrap_y", py(0), 4);

        // Spawn clamp when ShipY < PROJ_H, plus X truncation
        ShipX = 10'd1020; ShipY = 10'd5; ProjActvt = 10'h004;
        tick(); ProjActvt = '0;
        check("clamp_y2", py(2), 0);
        check("trunc_x2", px(2), 11);
        check("clamp_en", ProjEn, 10'h004);
        tick();
        check("clamp_exit", ProjEn, 0);

        // Hit with simultaneous relaunch request in FLY, then relaunch in IDLE with hit
        ShipX = 10'd300; ShipY = 10'd440; ProjActvt = 10'h008;
        tick();
        check("s3_fly", ProjEn, 10'h008);
        ProjActvt = 10'h008; ProjHit = 10'h008;
        tick();
        check("s3_hit", ProjEn, 0);
        check("s3_hold_y", py(3), 432);
        ShipX = 10'd100; ShipY = 10'd200;
        tick();
        idle_inputs();
        check("s3_relaunch", ProjEn, 10'h008);
        check("s3_relaunch_x", px(3), 115);
        check("s3_relaunch_y", py(3), 192);

        // Freeze holds positions and drops launches; hit still retires
        Reset = 1'b1; tick(); Reset = 1'b0;
        ShipX = 10'd300; ShipY = 10'd440; ProjActvt = 10'h003;
        tick();
        Freeze = 1'b1; ProjActvt = 10'h004;
        for (int f = 0; f < 5; f++) begin
            tick();
            check("frz_en", ProjEn, 10'h003);
            check("frz_y0", py(0), 432);
            check("frz_y1", py(1), 432);
        end
        ProjActvt = '0; ProjHit = 10'h002;
        tick();
        check("frz_hit_en", ProjEn, 10'h001);
        check("frz_hit_y1", py(1), 432);
        idle_inputs();
        tick();
        check("unfrz_y0", py(0), 426);
        check("unfrz_en", ProjEn, 10'h001);

        // All slots flying, then reset mid-flight
        ProjActvt = 10'h3FF;
        tick();
        check("all_en", ProjEn, 10'h3FF);
        check("all_y9", py(9), 432);
        Reset = 1'b1;
        tick();
        Reset = 1'b0; idle_inputs();
        check("rst_mid_en", ProjEn, 0);
        check("rst_mid_x", ProjX, 0);
        check("rst_mid_y", ProjY, 0);

`ifdef PROJ_SHOT_STATS_EN
        ProjActvt = 10'h007;
        tick();
        ProjActvt = '0; ProjHit = 10'h003;
        tick();
        idle_inputs();
        check("shots_fired", ShotsFired, 3);
        check("shots_hit", ShotsHit, 2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
